// File: rtl/cpa_carry_resolve.sv
// Sequential carry resolver: resolves one BIT_LEN-bit segment of a g/p vector per cycle.
// Optional carry_in port enabled by defining CPA_CARRY_IN_EN.
module cpa_carry_resolve #(
    parameter int BIT_LEN = 17,
    parameter int NUM_SEG = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_SEG*BIT_LEN-1:0] g,
    input  logic [NUM_SEG*BIT_LEN-1:0] p,
`ifdef CPA_CARRY_IN_EN
    input  logic                       carry_in,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_SEG*BIT_LEN-1:0] sum,
    output logic                       carry_out
);

    localparam int W     = NUM_SEG * BIT_LEN;
    localparam int SEG_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [SEG_W-1:0]   seg_idx_r;
    logic               carry_r;
    logic [W-1:0]       g_r;
    logic [W-1:0]       p_r;
    logic [W-1:0]       sum_r;
    logic               carry_out_r;
    logic               out_valid_r;

    logic [BIT_LEN-1:0] g_seg_s;
    logic [BIT_LEN-1:0] p_seg_s;
    logic [BIT_LEN:0]   seg_res_s;
    logic               accept_s;
    logic               last_seg_s;
    logic               carry_in_s;

    // Ripple one segment: returns {carry out of segment, segment sum}.
    function automatic logic [BIT_LEN:0] resolve_seg(
        input logic [BIT_LEN-1:0] gs,
        input logic [BIT_LEN-1:0] ps,
        input logic               cin
    );
        logic [BIT_LEN:0]   c;
        logic [BIT_LEN-1:0] s;
        c    = '0;
        c[0] = cin;
        for (int j = 0; j < BIT_LEN; j++) begin
            s[j]   = ps[j] ^ c[j];
            c[j+1] = gs[j] | (ps[j] & c[j]);
        end
        return {c[BIT_LEN], s};
    endfunction

`ifdef CPA_CARRY_IN_EN
    assign carry_in_s = carry_in;
`else
    assign carry_in_s = 1'b0;
`endif

    // Handshake and segment selection from the current state.
    always_comb begin
        in_ready   = ~reset & ((state_r == IDLE) | ((state_r == DONE) & out_ready));
        accept_s   = in_valid & in_ready;
        last_seg_s = (seg_idx_r == SEG_W'(NUM_SEG - 1));
        g_seg_s    = g_r[seg_idx_r*BIT_LEN +: BIT_LEN];
        p_seg_s    = p_r[seg_idx_r*BIT_LEN +: BIT_LEN];
        seg_res_s  = resolve_seg(g_seg_s, p_seg_s, carry_r);
    end

    // Control FSM with operand latch, per-segment sum write-back and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            seg_idx_r   <= '0;
            carry_r     <= 1'b0;
            g_r         <= '0;
            p_r         <= '0;
            sum_r       <= '0;
            carry_out_r <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        g_r       <= g;
                        p_r       <= p;
                        carry_r   <= carry_in_s;
                        seg_idx_r <= '0;
                        state_r   <= BUSY;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                BUSY: begin
                    sum_r[seg_idx_r*BIT_LEN +: BIT_LEN] <= seg_res_s[BIT_LEN-1:0];
                    carry_r <= seg_res_s[BIT_LEN];
                    if (last_seg_s) begin
                        carry_out_r <= seg_res_s[BIT_LEN];
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        seg_idx_r   <= seg_idx_r + SEG_W'(1);
                    end
                end
                DONE: begin
                    // A new operand may be taken on the same edge the result retires.
                    if (accept_s) begin
                        g_r         <= g;
                        p_r         <= p;
                        carry_r     <= carry_in_s;
                        seg_idx_r   <= '0;
                        out_valid_r <= 1'b0;
                        state_r     <= BUSY;
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign carry_out = carry_out_r;

endmodule

// File: tb/tb_cpa_carry_resolve.sv
// Scoreboard bench for cpa_carry_resolve: directed vectors, back-to-back, backpressure, mid-op reset.
module tb_cpa_carry_resolve;

    localparam int BIT_LEN = 17;
    localparam int NUM_SEG = 4;
    localparam int W       = 68;
    localparam int NV      = 11;

    localparam logic [W-1:0] VA [NV] = '{
        68'hF_FFFF_FFFF_FFFF_FFFF, 68'h0_0000_0000_0001_0000, 68'h0,
        68'h0_0000_0000_0001_FFFF, 68'hF_FFFF_FFFF_FFFF_FFFF, 68'h8_0000_0000_0000_0000,
        68'h1_2345_6789_ABCD_EF01, 68'hA_AAAA_AAAA_AAAA_AAAA, 68'hA_AAAA_AAAA_AAAA_AAAA,
        68'h0_0000_0002_0000_0000, 68'h0_0004_0000_0000_0000};
    localparam logic [W-1:0] VB [NV] = '{
        68'h1, 68'h0_0000_0000_0001_0000, 68'h0,
        68'h1, 68'hF_FFFF_FFFF_FFFF_FFFF, 68'h8_0000_0000_0000_0000,
        68'h0_1111_1111_1111_1111, 68'h5_5555_5555_5555_5555, 68'h5_5555_5555_5555_5556,
        68'h0_0000_0002_0000_0000, 68'h0_0004_0000_0000_0000};
    localparam logic [W-1:0] VS [NV] = '{
        68'h0, 68'h0_0000_0000_0002_0000, 68'h0,
        68'h0_0000_0000_0002_0000, 68'hF_FFFF_FFFF_FFFF_FFFE, 68'h0,
        68'h1_3456_789A_BCDF_0012, 68'hF_FFFF_FFFF_FFFF_FFFF, 68'h0,
        68'h0_0000_0004_0000_0000, 68'h0_0008_0000_0000_0000};
    localparam logic VC [NV] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] g;
    logic [W-1:0] p;
`ifdef CPA_CARRY_IN_EN
    logic         carry_in;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;

    exp_t         sb[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_errors = 0;
    int           busy_left = 0;
    bit           bb = 1'b0;
    bit           bp = 1'b0;
    bit           have_last = 1'b0;
    int           last_pop = 0;
    logic         prev_valid = 1'b0;
    logic         prev_ready = 1'b0;
    logic [W:0]   held = '0;

    cpa_carry_resolve #(.BIT_LEN(BIT_LEN), .NUM_SEG(NUM_SEG)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .g        (g),
        .p        (p),
`ifdef CPA_CARRY_IN_EN
        .carry_in (carry_in),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W:0] got, input logic [W:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Backpressure pattern applied while bp is set.
    always @(posedge clk) begin
        if (bp) begin
            #1 out_ready = ((cyc % 7) >= 3);
        end
    end

    // Monitor: latency, stall stability, in-order results, in_ready low while busy.
    always @(negedge clk) begin
        if (reset) begin
            busy_left  = 0;
            sb.delete();
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            have_last  = 1'b0;
        end else begin
            if (busy_left > 0) begin
                check("in_ready_busy", {68'd0, in_ready}, 69'd0);
                busy_left--;
            end
            if (in_valid && in_ready) busy_left = NUM_SEG;
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) check("spurious_output", {68'd0, out_valid}, 69'd0);
                else check("latency", 69'(cyc - sb[0].acc), 69'(NUM_SEG + 1));
            end
            if (out_valid && prev_valid && !prev_ready)
                check("stall_stable", {carry_out, sum}, held);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_result", {68'd0, out_valid}, 69'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", {carry_out, sum}, {e.c, e.s});
                end
                if (bb && have_last) check("bb_period", 69'(cyc - last_pop), 69'(NUM_SEG + 1));
                last_pop  = cyc;
                have_last = 1'b1;
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            held       = {carry_out, sum};
        end
    end

    // Present one operand and wait (bounded) for acceptance; in_valid is left high.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] es, input logic ec);
        bit ok;
        ok       = 1'b0;
        g        = a & b;
        p        = a ^ b;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{s: es, c: ec, acc: cyc});
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 69'd0, 69'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 69'(sb.size()), 69'd0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        g         = '0;
        p         = '0;
`ifdef CPA_CARRY_IN_EN
        carry_in  = 1'b0;
`endif
        @(negedge clk);
        check("in_ready_in_reset", {68'd0, in_ready}, 69'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_out_valid", {68'd0, out_valid}, 69'd0);
        check("reset_sum_cout", {carry_out, sum}, 69'd0);
        check("idle_in_ready", {68'd0, in_ready}, 69'd1);
        @(posedge clk);
        #1;

        // Single operands: full-width carry chain, then segment 0/1 crossing.
        send(VA[0], VB[0], VS[0], VC[0]);
        drain();
        send(VA[1], VB[1], VS[1], VC[1]);
        drain();

        // Back-to-back with in_valid and out_ready held high.
        bb        = 1'b1;
        have_last = 1'b0;
        for (int i = 2; i < NV; i++) send(VA[i], VB[i], VS[i], VC[i]);
        drain();
        bb = 1'b0;

        // All vectors again under backpressure.
        bp = 1'b1;
        for (int i = 0; i < NV; i++) send(VA[i], VB[i], VS[i], VC[i]);
        drain();
        bp = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;

        // Reset during the third BUSY cycle discards the operation.
        send(VA[4], VB[4], VS[4], VC[4]);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("in_ready_in_reset2", {68'd0, in_ready}, 69'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midop_reset_valid", {68'd0, out_valid}, 69'd0);
        check("midop_reset_sum", {carry_out, sum}, 69'd0);
        check("midop_reset_ready", {68'd0, in_ready}, 69'd1);
        repeat (8) @(posedge clk);
        #1;
        check("no_result_after_reset", 69'(sb.size()), 69'd0);
        send(VA[6], VB[6], VS[6], VC[6]);
        drain();

`ifdef CPA_CARRY_IN_EN
        // carry_in into an all-propagate vector; toggling it while busy must not matter.
        carry_in = 1'b1;
        send(68'hF_FFFF_FFFF_FFFF_FFFF, 68'h0, 68'h0, 1'b1);
        in_valid = 1'b0;
        for (int i = 0; i < NUM_SEG; i++) begin
            carry_in = ~carry_in;
            @(posedge clk);
            #1;
        end
        drain();
        carry_in = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
